// File: rtl/popcount_pkg.sv
// Shared definitions for the multi-cycle population counter.
//   state_e     : engine FSM encoding (ST_IDLE, ST_COUNT, ST_DONE)
//   MODE_ONES   : in_mode value that counts ones
//   MODE_ZEROS  : in_mode value that counts zeros
//   clog2()     : ceil(log2(value)), usable in parameter expressions
package popcount_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic MODE_ONES  = 1'b0;
    localparam logic MODE_ZEROS = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational ones counter for one CHUNK-bit slice of the word.
// Ports:
//   bits_i : CHUNK-bit slice to count
//   sum_o  : number of ones in bits_i, clog2(CHUNK+1) bits
module popcount_chunk
    import popcount_pkg::*;
#(
    parameter  int CHUNK = 8,
    localparam int SUM_W = clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] bits_i,
    output logic [SUM_W-1:0] sum_o
);

    // Written as a chain; synthesis rebalances it into an adder tree.
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < CHUNK; i++) begin
            sum_o = sum_o + SUM_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/popcount_engine.sv
// Multi-cycle population counter: counts ones (or zeros) in a WIDTH-bit word,
// CHUNK bits per clock, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (in_ready high only in IDLE)
//   in_data, in_mode     : word to count; mode 0 = ones, 1 = zeros
//   out_valid / out_ready: output handshake
//   out_count, out_parity: result and its LSB, held until the next result
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a word, in_ready=1
// ST_COUNT | consuming CHUNK bits per cycle, NCHK cycles
// ST_DONE  | result presented, waiting for out_ready
module popcount_engine
    import popcount_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int CHUNK = 8,
    localparam int CNT_W = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_parity
);

    localparam int NCHK  = WIDTH / CHUNK;
    localparam int SUM_W = clog2(CHUNK + 1);
    localparam int IDX_W = clog2(NCHK + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   chunk_sum;
    logic [CNT_W-1:0]   acc_next;

    popcount_chunk #(.CHUNK(CHUNK)) u_chunk (
        .bits_i (shreg_q[CHUNK-1:0]),
        .sum_o  (chunk_sum)
    );

    // acc never exceeds WIDTH, so CNT_W bits cannot wrap.
    assign acc_next = acc_q + CNT_W'(chunk_sum);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Counting zeros is counting ones of the inverted word.
                    shreg_d = (in_mode == MODE_ZEROS) ? ~in_data : in_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                acc_d   = acc_next;
                shreg_d = shreg_q >> CHUNK;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NCHK - 1)) begin
                    cnt_d   = acc_next;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_count  = cnt_q;
    assign out_parity = cnt_q[0];

endmodule

// File: tb/tb_popcount_engine.sv
// Bench for popcount_engine: three instances (W32/C8, W8/C1, W8/C8) checked
// every cycle against a bit-summing reference with a result queue per instance.
module tb_popcount_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        iv[3];
    logic        im[3];
    logic        ordy[3];
    logic [31:0] id[3];
    logic        ir[3];
    logic        ov[3];
    logic        op[3];
    logic [5:0]  c0;
    logic [3:0]  c1;
    logic [3:0]  c2;
    int          oc[3];

    always_comb begin
        oc[0] = int'(c0);
        oc[1] = int'(c1);
        oc[2] = int'(c2);
    end

    popcount_engine #(.WIDTH(32), .CHUNK(8)) u_w32c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .in_mode(im[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_count(c0), .out_parity(op[0]));

    popcount_engine #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1][7:0]), .in_mode(im[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_count(c1), .out_parity(op[1]));

    popcount_engine #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(id[2][7:0]), .in_mode(im[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .out_count(c2), .out_parity(op[2]));

    int total = 0;
    int bad   = 0;
    int wk[3] = '{32, 8, 8};
    int nk[3] = '{4, 8, 1};

    task automatic chk(input string nm, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: number of bits in the low w bits that differ from the mode bit.
    function automatic int ref_pop(input logic [31:0] d, input int w, input logic m);
        int n;
        n = 0;
        for (int i = 0; i < w; i++) begin
            if (d[i] != m) n++;
        end
        return n;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_q[3][$];
    int acc_c[3][$];
    int log_cnt[$];
    int log_cyc[$];

    // Compare process: one word in flight per instance; valid appears NCHK+1
    // sampled cycles after the cycle in which the word was offered in IDLE.
    always @(negedge clk) begin
        bit busy;
        bit ev;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                exp_q[k].delete();
                acc_c[k].delete();
                chk($sformatf("u%0d reset in_ready", k), int'(ir[k]), 1);
                chk($sformatf("u%0d reset out_valid", k), int'(ov[k]), 0);
                chk($sformatf("u%0d reset out_count", k), oc[k], 0);
                chk($sformatf("u%0d reset out_parity", k), int'(op[k]), 0);
            end else begin
                busy = (exp_q[k].size() != 0);
                ev = 1'b0;
                if (busy) ev = ((cyc - acc_c[k][0]) >= nk[k] + 1);
                chk($sformatf("u%0d in_ready", k), int'(ir[k]), int'(!busy));
                chk($sformatf("u%0d out_valid", k), int'(ov[k]), int'(ev));
                if (ov[k] && ev) begin
                    chk($sformatf("u%0d out_count", k), oc[k], exp_q[k][0]);
                    chk($sformatf("u%0d out_parity", k), int'(op[k]), exp_q[k][0] % 2);
                    if (ordy[k]) begin
                        if (k == 0) begin
                            log_cnt.push_back(oc[k]);
                            log_cyc.push_back(cyc);
                        end
                        void'(exp_q[k].pop_front());
                        void'(acc_c[k].pop_front());
                    end
                end
                if (iv[k] && !busy) begin
                    exp_q[k].push_back(ref_pop(id[k], wk[k], im[k]));
                    acc_c[k].push_back(cyc);
                end
            end
        end
    end

    // Offer a word to instance k and return just after the accepting edge.
    task automatic send(input int k, input logic [31:0] d, input logic m);
        int t;
        iv[k] = 1'b1;
        id[k] = d;
        im[k] = m;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ir[k] && t < 100);
        if (!ir[k]) chk($sformatf("u%0d accept timeout", k), 0, 1);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    // Full transaction on the 32-bit instance with hold cycles of out_ready low,
    // during which a competing word is offered.
    task automatic run32(input logic [31:0] d, input logic m, input int hold,
                         input logic [31:0] intruder,
                         output int cnt, output int par, output int lat);
        ordy[0] = 1'b0;
        send(0, d, m);
        lat = 0;
        while (!ov[0] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!ov[0]) chk("u0 result timeout", 0, 1);
        for (int i = 0; i < hold; i++) begin
            iv[0] = 1'b1;
            id[0] = intruder;
            chk("hold out_valid", int'(ov[0]), 1);
            chk("hold in_ready", int'(ir[0]), 0);
            @(posedge clk);
            #1;
        end
        iv[0]   = 1'b0;
        cnt     = oc[0];
        par     = int'(op[0]);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt, par, lat, t;
        int words[3];
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; im[k] = 1'b0; ordy[k] = 1'b0; id[k] = '0;
        end
        words = '{32'h1, 32'h3, 32'h7};

        chk("model F0 zeros", ref_pop(32'h0000_00F0, 32, 1'b1), 28);
        chk("model 8000_0001 ones", ref_pop(32'h8000_0001, 32, 1'b0), 2);
        chk("model A5 zeros w8", ref_pop(32'h0000_00A5, 8, 1'b1), 4);

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run32(32'hFFFF_FFFF, 1'b0, 0, 32'h0, cnt, par, lat);
        chk("t1 count", cnt, 32);
        chk("t1 parity", par, 0);
        chk("t1 latency", lat, 4);

        run32(32'h0000_00F0, 1'b1, 0, 32'h0, cnt, par, lat);
        chk("t2 zeros count", cnt, 28);
        run32(32'h0000_0000, 1'b0, 0, 32'h0, cnt, par, lat);
        chk("t2 zero word", cnt, 0);

        run32(32'h8000_0001, 1'b0, 5, 32'hFFFF_FFFF, cnt, par, lat);
        chk("t3 count", cnt, 2);
        chk("t3 parity", par, 0);

        send(0, 32'hDEAD_BEEF, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t4 in_ready", int'(ir[0]), 1);
        chk("t4 out_valid", int'(ov[0]), 0);
        chk("t4 out_count", oc[0], 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run32(32'h0F0F_0F0F, 1'b0, 0, 32'h0, cnt, par, lat);
        chk("t4 next count", cnt, 16);

        log_cnt.delete();
        log_cyc.delete();
        ordy[0] = 1'b1;
        for (int i = 0; i < 3; i++) send(0, words[i], 1'b0);
        t = 0;
        while (log_cnt.size() < 3 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (log_cnt.size() >= 3) begin
            chk("t5 result0", log_cnt[0], 1);
            chk("t5 result1", log_cnt[1], 2);
            chk("t5 result2", log_cnt[2], 3);
            chk("t5 spacing01", log_cyc[1] - log_cyc[0], 6);
            chk("t5 spacing12", log_cyc[2] - log_cyc[1], 6);
        end else begin
            chk("t5 result timeout", log_cnt.size(), 3);
        end
        ordy[0] = 1'b0;

        repeat (400) begin
            iv[0] = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       id[0] = '0;
                1:       id[0] = '1;
                default: id[0] = $urandom;
            endcase
            im[0]   = 1'($urandom_range(0, 1));
            ordy[0] = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1 ordy[0] = 1'b0;

        ordy[1] = 1'b1;
        ordy[2] = 1'b1;
        for (int k = 1; k < 3; k++) begin
            for (int m = 0; m < 2; m++) begin
                for (int v = 0; v < 256; v++) begin
                    send(k, 32'(v), 1'(m));
                end
            end
        end
        repeat (12) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
